// File: rtl/special_result_encoder_div.sv
// Special-case result encoder for a HUB-format divider: classifies the operands,
// selects the final quotient (or passes the datapath quotient through) and raises IEEE-style flags.
module special_result_encoder_div #(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int special_case = 7,
    localparam int C           = (special_case > 1) ? $clog2(special_case) : 1,
    localparam int W           = E + M + 1
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic [C-1:0] X_special_case,
    input  logic [C-1:0] Y_special_case,
    input  logic         X_one,
    input  logic [W-1:0] Q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Z,
    output logic         flag_invalid,
    output logic         flag_div_zero,
    output logic         sticky_invalid,
    output logic         sticky_div_zero,
    input  logic         clear_flags
);

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_INF  = 2'd1;
    localparam logic [1:0] KIND_ZERO = 2'd2;
    localparam logic [1:0] KIND_ONE  = 2'd3;

    localparam logic [3:0] RULE_INV_INF  = 4'd0;
    localparam logic [3:0] RULE_INV_ZERO = 4'd1;
    localparam logic [3:0] RULE_X_INF    = 4'd2;
    localparam logic [3:0] RULE_Y_ZERO   = 4'd3;
    localparam logic [3:0] RULE_X_ZERO   = 4'd4;
    localparam logic [3:0] RULE_Y_INF    = 4'd5;
    localparam logic [3:0] RULE_ONE      = 4'd6;
    localparam logic [3:0] RULE_Y_ONE    = 4'd7;
    localparam logic [3:0] RULE_PASS     = 4'd8;

    // Signed zeros/infinities/ones collapse to a kind; the sign comes from the operand itself.
    function automatic logic [1:0] decode_kind(input logic [C-1:0] code);
        logic [1:0] kind;
        case (int'(code))
            32'sd1, 32'sd2: kind = KIND_INF;
            32'sd3, 32'sd4: kind = KIND_ZERO;
            32'sd5, 32'sd6: kind = KIND_ONE;
            default:        kind = KIND_NONE;
        endcase
        return kind;
    endfunction

    logic [1:0]   x_kind_s;
    logic [1:0]   y_kind_s;
    logic [3:0]   rule_s;
    logic         sign_s;
    logic         adv1_s;
    logic         adv2_s;
    logic         xfer_s;
    logic [W-1:0] z_next_s;
    logic         inv_next_s;
    logic         dz_next_s;

    logic         s1_valid_r;
    logic [3:0]   s1_rule_r;
    logic         s1_sign_r;
    logic [W-2:0] s1_payload_r;
    logic [W-1:0] s1_q_r;
    logic         s2_valid_r;

    assign adv2_s    = !s2_valid_r || out_ready;
    assign adv1_s    = !s1_valid_r || adv2_s;
    assign in_ready  = adv1_s;
    assign out_valid = s2_valid_r;
    assign xfer_s    = s2_valid_r && out_ready;
    assign x_kind_s  = decode_kind(X_special_case);
    assign y_kind_s  = decode_kind(Y_special_case);
    assign sign_s    = X[E+M] ^ Y[E+M];

    // First-match rule selection over the operand classes.
    always_comb begin
        rule_s = RULE_PASS;
        if ((x_kind_s == KIND_INF) && (y_kind_s == KIND_INF)) begin
            rule_s = RULE_INV_INF;
        end else if ((x_kind_s == KIND_ZERO) && (y_kind_s == KIND_ZERO)) begin
            rule_s = RULE_INV_ZERO;
        end else if (x_kind_s == KIND_INF) begin
            rule_s = RULE_X_INF;
        end else if (y_kind_s == KIND_ZERO) begin
            rule_s = RULE_Y_ZERO;
        end else if (x_kind_s == KIND_ZERO) begin
            rule_s = RULE_X_ZERO;
        end else if (y_kind_s == KIND_INF) begin
            rule_s = RULE_Y_INF;
        end else if ((y_kind_s == KIND_ONE) && X_one) begin
            rule_s = RULE_ONE;
        end else if (y_kind_s == KIND_ONE) begin
            rule_s = RULE_Y_ONE;
        end else begin
            rule_s = RULE_PASS;
        end
    end

    // Stage 1: capture the classification and the operands the encoder may still need.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_valid_r   <= 1'b0;
            s1_rule_r    <= RULE_PASS;
            s1_sign_r    <= 1'b0;
            s1_payload_r <= '0;
            s1_q_r       <= '0;
        end else if (adv1_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_rule_r    <= rule_s;
                s1_sign_r    <= sign_s;
                s1_payload_r <= X[E+M-1:0];
                s1_q_r       <= Q;
            end
        end
    end

    // Result encoding from the registered rule; invalid results are always the positive NaN pattern.
    always_comb begin
        z_next_s   = s1_q_r;
        inv_next_s = 1'b0;
        dz_next_s  = 1'b0;
        case (s1_rule_r)
            RULE_INV_INF, RULE_INV_ZERO: begin
                z_next_s   = {1'b0, {(W-1){1'b1}}};
                inv_next_s = 1'b1;
            end
            RULE_X_INF:  z_next_s = {s1_sign_r, {(W-1){1'b1}}};
            RULE_Y_ZERO: begin
                z_next_s  = {s1_sign_r, {(W-1){1'b1}}};
                dz_next_s = 1'b1;
            end
            RULE_X_ZERO, RULE_Y_INF: z_next_s = {s1_sign_r, {(W-1){1'b0}}};
            RULE_ONE:    z_next_s = {s1_sign_r, 1'b1, {(E+M-1){1'b0}}};
            RULE_Y_ONE:  z_next_s = {s1_sign_r, s1_payload_r};
            default:     z_next_s = s1_q_r;
        endcase
    end

    // Stage 2: output register, frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s2_valid_r    <= 1'b0;
            Z             <= '0;
            flag_invalid  <= 1'b0;
            flag_div_zero <= 1'b0;
        end else if (adv2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                Z             <= z_next_s;
                flag_invalid  <= inv_next_s;
                flag_div_zero <= dz_next_s;
            end
        end
    end

    // Sticky flags accumulate on delivered results; a set in the same cycle beats a clear.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sticky_invalid  <= 1'b0;
            sticky_div_zero <= 1'b0;
        end else begin
            if (xfer_s && flag_invalid) begin
                sticky_invalid <= 1'b1;
            end else if (clear_flags) begin
                sticky_invalid <= 1'b0;
            end
            if (xfer_s && flag_div_zero) begin
                sticky_div_zero <= 1'b1;
            end else if (clear_flags) begin
                sticky_div_zero <= 1'b0;
            end
        end
    end

endmodule

// File: doc/special_result_encoder_div.md
SPECIAL_RESULT_ENCODER_DIV -- requirements
Module: special_result_encoder_div

Interface
REQ-001 SHALL have parameter M, default 23, mantissa width.
REQ-002 SHALL have parameter E, default 8, exponent width.
REQ-003 SHALL have parameter special_case, default 7, number of case codes; code width C = $clog2(special_case).
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- rst_l  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- X  in  E+M+1  dividend, HUB format.
- Y  in  E+M+1  divisor, HUB format.
- X_special_case  in  C  dividend case code.
- Y_special_case  in  C  divisor case code.
- X_one  in  1  dividend is ±1.
- Q  in  E+M+1  datapath quotient, aligned with X/Y.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- Z  out  E+M+1  final quotient.
- flag_invalid  out  1  0/0 or inf/inf.
- flag_div_zero  out  1  finite nonzero / zero.
- sticky_invalid  out  1  accumulated flag_invalid.
- sticky_div_zero  out  1  accumulated flag_div_zero.
- clear_flags  in  1  synchronous clear of sticky flags.

Function
REQ-005 SHALL decode codes: 0 none, 1 +inf, 2 -inf, 3 +0, 4 -0, 5 +1, 6 -1; any other value SHALL be treated as 0.
REQ-006 SHALL take sign sx = X[E+M], sy = Y[E+M]; result sign s = sx ^ sy.
REQ-007 SHALL encode inf as {s, all ones}, zero as {s, all zeros}, one as {s, 1'b1, zeros(E+M-1)}.
REQ-008 SHALL select Z by first matching rule:
- X inf and Y inf -> {0, all ones}, flag_invalid=1.
- X zero and Y zero -> {0, all ones}, flag_invalid=1.
- X inf -> inf(s).
- Y zero -> inf(s), flag_div_zero=1.
- X zero -> zero(s).
- Y inf -> zero(s).
- Y ±1 and X_one -> one(s).
- Y ±1 -> {s, X[E+M-1:0]}.
- otherwise -> Q unchanged.
REQ-009 SHALL zero both flags unless a rule above sets one.
REQ-010 SHALL be a 2-stage pipeline: stage 1 registers classification (rule index, s, X payload, Q); stage 2 registers Z and flags.
REQ-011 SHALL present result exactly 2 cycles after acceptance when out_ready stays high; throughput one beat per cycle.
REQ-012 SHALL advance stage 2 when !s2_valid || out_ready; stage 1 when !s1_valid || stage 2 advances; in_ready = !s1_valid || stage-2-advance.
REQ-013 SHALL hold Z, flags, out_valid stable while out_valid && !out_ready.
REQ-014 SHALL drop no beat and duplicate no beat under arbitrary in_valid/out_ready patterns; order preserved.
REQ-015 SHALL set sticky flags on output transfer (out_valid && out_ready) with the matching flag high.
REQ-016 SHALL clear sticky flags on clear_flags; a simultaneous set SHALL win (sticky remains 1).
REQ-017 SHALL ignore X, Y, codes, Q when in_valid is low.

Reset
REQ-018 SHALL on rst_l low asynchronously clear s1_valid, s2_valid, out_valid, Z, flag_invalid, flag_div_zero, sticky_invalid, sticky_div_zero to 0.
REQ-019 SHALL discard in-flight beats on reset mid-operation; in_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-020 SHALL cover: E=8,M=23, X code 1, Y code 6, sx=0, sy=1, out_ready=1 -> Z=32'hFFFF_FFFF (sign 1), flags 0, out_valid 2 cycles after accept.
REQ-021 SHALL cover: X code 3, Y code 4 -> Z=32'h7FFF_FFFF, flag_invalid=1, sticky_invalid=1 after transfer; then clear_flags pulse -> sticky_invalid=0.
REQ-022 SHALL cover: X=32'h4040_0000 code 0, Y code 3 -> Z=32'h7FFF_FFFF, flag_div_zero=1.
REQ-023 SHALL cover: X=32'hC120_0000 code 0, Y code 6 -> Z=32'h4120_0000; Y code 0, Q=32'h1234_5678 -> Z=32'h1234_5678.
REQ-024 SHALL cover: 8 back-to-back beats with out_ready toggling 1,0,0,1 -> all 8 results in order, none lost, Z stable while stalled, in_ready low only when both stages full and out_ready low.
REQ-025 SHALL cover: rst_l asserted with both stages full -> out_valid=0 immediately, no stale beat after release.
